// File: rtl/branch_pkg.sv
// branch_pkg: shared definitions for the branch resolver.
//   - condition-code constants decoded by cond_eval and branch_unit
//   - FSM state enum for branch_unit
//   - bit positions of the comparison flags inside the 5-bit flag word
//     {lt, gt, eq, zb, za}
package branch_pkg;

    localparam logic [3:0] COND_ALWAYS = 4'd0;
    localparam logic [3:0] COND_EQ     = 4'd1;
    localparam logic [3:0] COND_NE     = 4'd2;
    localparam logic [3:0] COND_GT     = 4'd3;
    localparam logic [3:0] COND_LT     = 4'd4;
    localparam logic [3:0] COND_GE     = 4'd5;
    localparam logic [3:0] COND_LE     = 4'd6;
    localparam logic [3:0] COND_ZA     = 4'd7;
    localparam logic [3:0] COND_NZA    = 4'd8;
    localparam logic [3:0] COND_ZB     = 4'd9;
    localparam logic [3:0] COND_NZB    = 4'd10;
    localparam logic [3:0] COND_DJNZ   = 4'd11;

    localparam int FLAG_ZA = 0;
    localparam int FLAG_ZB = 1;
    localparam int FLAG_EQ = 2;
    localparam int FLAG_GT = 3;
    localparam int FLAG_LT = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_REDIRECT,
        ST_FLUSH
    } state_t;

endpackage

// File: rtl/cond_eval.sv
// cond_eval: purely combinational decode of a condition code against the
// latched comparison flags.
// Ports:
//   cond   in  4  condition code
//   flags  in  5  latched flags {lt, gt, eq, zb, za}
//   taken  out 1  condition satisfied
// DJNZ depends on the loop counter and is resolved in branch_unit, so it
// decodes here as never taken, like codes 12-15.
module cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_ALWAYS: taken = 1'b1;
            COND_EQ:     taken = flags[FLAG_EQ];
            COND_NE:     taken = ~flags[FLAG_EQ];
            COND_GT:     taken = flags[FLAG_GT];
            COND_LT:     taken = flags[FLAG_LT];
            COND_GE:     taken = flags[FLAG_GT] | flags[FLAG_EQ];
            COND_LE:     taken = flags[FLAG_LT] | flags[FLAG_EQ];
            COND_ZA:     taken = flags[FLAG_ZA];
            COND_NZA:    taken = ~flags[FLAG_ZA];
            COND_ZB:     taken = flags[FLAG_ZB];
            COND_NZB:    taken = ~flags[FLAG_ZB];
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// branch_unit: conditional branch resolver. Latches compare flags, accepts a
// branch request over valid/ready, evaluates it one cycle later against the
// latched flags and, when taken, emits a one-cycle redirect plus a flush pulse
// lasting FLUSH_CYCLES cycles.
// Parameters:
//   PC_W          width of PC, offset and target
//   FLUSH_CYCLES  total flush length per taken branch (1..15)
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   flag_we, flags_in, flags_q       flag register write / data / value
//   br_valid, br_ready               request handshake
//   br_cond, br_pc, br_offset        request payload
//   redirect_valid, redirect_pc      one-cycle redirect to fetch
//   flush                            squash younger instructions
//   lc_we, lc_din, lc_q              loop counter (LOOP_CTR_EN only)
// Build option: define LOOP_CTR_EN to add the loop counter and DJNZ support;
// without it code 11 is never taken.
module branch_unit
    import branch_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int FLUSH_CYCLES = 2
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flag_we,
    input  logic [4:0]      flags_in,
    output logic [4:0]      flags_q,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [3:0]      br_cond,
    input  logic [PC_W-1:0] br_pc,
    input  logic [PC_W-1:0] br_offset,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush
`ifdef LOOP_CTR_EN
    ,
    input  logic            lc_we,
    input  logic [PC_W-1:0] lc_din,
    output logic [PC_W-1:0] lc_q
`endif
);

    state_t          state;
    logic [3:0]      cond_r;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] off_r;
    logic [3:0]      flush_cnt;
    logic            cond_taken;
    logic            djnz_taken;
    logic            taken;
    logic [PC_W-1:0] target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flags_q <= '0;
        else if (flag_we)
            flags_q <= flags_in;
    end

    cond_eval u_cond_eval (
        .cond  (cond_r),
        .flags (flags_q),
        .taken (cond_taken)
    );

    // Target wraps modulo 2^PC_W; the offset is two's complement, so a plain
    // unsigned add gives the right answer for backward branches too.
    assign target = pc_r + PC_W'(1) + off_r;

`ifdef LOOP_CTR_EN
    logic lc_dec;

    // Decrement only on a DJNZ evaluation with a non-zero counter; taken when
    // the decremented value is still non-zero, i.e. the old value was not 1.
    assign lc_dec     = (state == ST_EVAL) && (cond_r == COND_DJNZ) && (lc_q != '0);
    assign djnz_taken = lc_dec && (lc_q != PC_W'(1));

    // A write from software wins over a decrement on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lc_q <= '0;
        else if (lc_we)
            lc_q <= lc_din;
        else if (lc_dec)
            lc_q <= lc_q - PC_W'(1);
    end
`else
    assign djnz_taken = 1'b0;
`endif

    assign taken = (cond_r == COND_DJNZ) ? djnz_taken : cond_taken;

    // flush_cnt counts the FLUSH-state cycles still to go after the current
    // one, so REDIRECT plus the FLUSH cycles add up to FLUSH_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            br_ready       <= 1'b1;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            cond_r         <= '0;
            pc_r           <= '0;
            off_r          <= '0;
            flush_cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (br_valid) begin
                        cond_r   <= br_cond;
                        pc_r     <= br_pc;
                        off_r    <= br_offset;
                        br_ready <= 1'b0;
                        state    <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (taken) begin
                        redirect_pc    <= target;
                        redirect_valid <= 1'b1;
                        flush          <= 1'b1;
                        state          <= ST_REDIRECT;
                    end else begin
                        br_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_REDIRECT: begin
                    redirect_valid <= 1'b0;
                    if (FLUSH_CYCLES > 1) begin
                        flush_cnt <= 4'(FLUSH_CYCLES - 2);
                        state     <= ST_FLUSH;
                    end else begin
                        flush    <= 1'b0;
                        br_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        flush    <= 1'b0;
                        br_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed self-checking bench for branch_unit.
// Define LOOP_CTR_EN for both DUT and bench to include the loop-counter cases.
module tb_branch_unit;

    localparam int PC_W = 16;
    localparam int FC   = 2;

    logic            clk;
    logic            rst_n;
    logic            flag_we;
    logic [4:0]      flags_in;
    logic [4:0]      flags_q;
    logic            br_valid;
    logic            br_ready;
    logic [3:0]      br_cond;
    logic [PC_W-1:0] br_pc;
    logic [PC_W-1:0] br_offset;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            flush;
`ifdef LOOP_CTR_EN
    logic            lc_we;
    logic [PC_W-1:0] lc_din;
    logic [PC_W-1:0] lc_q;
`endif

    int              vecCount;
    int              missCount;
    logic [PC_W-1:0] lastTarget;

    branch_unit #(
        .PC_W         (PC_W),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flag_we        (flag_we),
        .flags_in       (flags_in),
        .flags_q        (flags_q),
        .br_valid       (br_valid),
        .br_ready       (br_ready),
        .br_cond        (br_cond),
        .br_pc          (br_pc),
        .br_offset      (br_offset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush)
`ifdef LOOP_CTR_EN
        ,
        .lc_we          (lc_we),
        .lc_din         (lc_din),
        .lc_q           (lc_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h, required %0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setFlags(input logic [4:0] f);
        flag_we  = 1'b1;
        flags_in = f;
        step();
        flag_we  = 1'b0;
        checkOutput("flags_q_write", flags_q, f);
    endtask

    // Presents one request and returns in the cycle after it was accepted.
    task automatic applyStimulus(input logic [3:0] c, input logic [PC_W-1:0] pc,
                                 input logic [PC_W-1:0] off);
        int waited;
        waited = 0;
        while (!br_ready && waited < 16) begin
            step();
            waited++;
        end
        if (!br_ready)
            checkOutput("ready_timeout", br_ready, 1);
        br_valid  = 1'b1;
        br_cond   = c;
        br_pc     = pc;
        br_offset = off;
        step();
        br_valid  = 1'b0;
        br_cond   = 4'hF;
    endtask

    task automatic runBranch(input string tag, input logic [3:0] c,
                             input logic [PC_W-1:0] pc, input logic [PC_W-1:0] off,
                             input logic expTaken, input logic [PC_W-1:0] expPc);
        applyStimulus(c, pc, off);
        checkOutput({tag, "_eval_ready"}, br_ready, 0);
        checkOutput({tag, "_eval_rv"}, redirect_valid, 0);
        step();
        checkOutput({tag, "_rv"}, redirect_valid, expTaken);
        checkOutput({tag, "_flush"}, flush, expTaken);
        if (expTaken) begin
            lastTarget = expPc;
            checkOutput({tag, "_target"}, redirect_pc, expPc);
            checkOutput({tag, "_redir_ready"}, br_ready, 0);
            for (int i = 1; i < FC; i++) begin
                step();
                checkOutput({tag, "_flush_hold"}, flush, 1);
                checkOutput({tag, "_rv_drop"}, redirect_valid, 0);
                checkOutput({tag, "_flush_ready"}, br_ready, 0);
            end
            step();
            checkOutput({tag, "_flush_end"}, flush, 0);
            checkOutput({tag, "_ready_back"}, br_ready, 1);
            checkOutput({tag, "_target_hold"}, redirect_pc, expPc);
        end else begin
            checkOutput({tag, "_nt_ready"}, br_ready, 1);
            checkOutput({tag, "_nt_target_hold"}, redirect_pc, lastTarget);
        end
    endtask

    initial begin
        vecCount   = 0;
        missCount  = 0;
        lastTarget = '0;
        rst_n      = 1'b0;
        flag_we    = 1'b0;
        flags_in   = '0;
        br_valid   = 1'b0;
        br_cond    = '0;
        br_pc      = '0;
        br_offset  = '0;
`ifdef LOOP_CTR_EN
        lc_we      = 1'b0;
        lc_din     = '0;
`endif

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        checkOutput("reset_ready", br_ready, 1);
        checkOutput("reset_rv", redirect_valid, 0);
        checkOutput("reset_flush", flush, 0);
        checkOutput("reset_flags", flags_q, 0);
        checkOutput("reset_target", redirect_pc, 0);

        $display("[TB] flags eq only");
        setFlags(5'b00100);
        runBranch("eq_taken",   4'd1,  16'h0010, 16'h0005, 1, 16'h0016);
        runBranch("gt_nt",      4'd3,  16'h0020, 16'h0001, 0, 16'h0000);
        runBranch("always_wrap",4'd0,  16'h0000, 16'hFFFE, 1, 16'hFFFF);
        runBranch("ne_nt",      4'd2,  16'h0030, 16'h0001, 0, 16'h0000);
        runBranch("lt_nt",      4'd4,  16'h0031, 16'h0001, 0, 16'h0000);
        runBranch("ge_eq",      4'd5,  16'h1234, 16'h0010, 1, 16'h1245);
        runBranch("le_eq_wrap", 4'd6,  16'h8000, 16'h7FFF, 1, 16'h0000);
        runBranch("za_nt",      4'd7,  16'h0032, 16'h0001, 0, 16'h0000);
        runBranch("nza",        4'd8,  16'h00FF, 16'h0000, 1, 16'h0100);
        runBranch("zb_nt",      4'd9,  16'h0033, 16'h0001, 0, 16'h0000);
        runBranch("nzb_back",   4'd10, 16'h0200, 16'hFF00, 1, 16'h0101);
        runBranch("never12",    4'd12, 16'h0034, 16'h0001, 0, 16'h0000);
        runBranch("never15",    4'd15, 16'h0035, 16'h0001, 0, 16'h0000);

        $display("[TB] flags lt, zb, za");
        setFlags(5'b10011);
        runBranch("za",         4'd7,  16'h0040, 16'h0002, 1, 16'h0043);
        runBranch("zb_back",    4'd9,  16'h0050, 16'hFFF0, 1, 16'h0041);
        runBranch("lt",         4'd4,  16'h0060, 16'h0004, 1, 16'h0065);
        runBranch("le_lt",      4'd6,  16'h0070, 16'h0000, 1, 16'h0071);
        runBranch("ge_nt",      4'd5,  16'h0080, 16'h0001, 0, 16'h0000);
        runBranch("eq_nt",      4'd1,  16'h0081, 16'h0001, 0, 16'h0000);
        runBranch("nza_nt",     4'd8,  16'h0082, 16'h0001, 0, 16'h0000);
        runBranch("nzb_nt",     4'd10, 16'h0083, 16'h0001, 0, 16'h0000);
        runBranch("gt_nt2",     4'd3,  16'h0084, 16'h0001, 0, 16'h0000);

        $display("[TB] flag write during EVAL does not bypass");
        setFlags(5'b00100);
        applyStimulus(4'd3, 16'h0400, 16'h0001);
        flag_we  = 1'b1;
        flags_in = 5'b01000;
        step();
        flag_we  = 1'b0;
        checkOutput("nobypass_rv", redirect_valid, 0);
        checkOutput("nobypass_flush", flush, 0);
        checkOutput("nobypass_ready", br_ready, 1);
        checkOutput("nobypass_flags", flags_q, 5'b01000);
        runBranch("gt_after",   4'd3,  16'h0300, 16'h0010, 1, 16'h0311);

        $display("[TB] reset during flush");
        applyStimulus(4'd0, 16'h0100, 16'h0010);
        step();
        checkOutput("rstflush_rv", redirect_valid, 1);
        checkOutput("rstflush_target", redirect_pc, 16'h0111);
        step();
        checkOutput("rstflush_in_flush", flush, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstflush_flush_drop", flush, 0);
        checkOutput("rstflush_ready", br_ready, 1);
        checkOutput("rstflush_rv0", redirect_valid, 0);
        checkOutput("rstflush_target0", redirect_pc, 0);
        checkOutput("rstflush_flags0", flags_q, 0);
        #2;
        rst_n = 1'b1;
        lastTarget = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("postrst_rv", redirect_valid, 0);
            checkOutput("postrst_flush", flush, 0);
            checkOutput("postrst_ready", br_ready, 1);
        end

        runBranch("djnz_zero_nt", 4'd11, 16'h0500, 16'h0002, 0, 16'h0000);

`ifdef LOOP_CTR_EN
        $display("[TB] loop counter");
        checkOutput("lc_zero_hold", lc_q, 0);
        lc_we  = 1'b1;
        lc_din = 16'd3;
        step();
        lc_we  = 1'b0;
        checkOutput("lc_load", lc_q, 3);
        runBranch("djnz1", 4'd11, 16'h0500, 16'h0002, 1, 16'h0503);
        checkOutput("lc_after1", lc_q, 2);
        runBranch("djnz2", 4'd11, 16'h0600, 16'h0000, 1, 16'h0601);
        checkOutput("lc_after2", lc_q, 1);
        runBranch("djnz3", 4'd11, 16'h0700, 16'h0000, 0, 16'h0000);
        checkOutput("lc_after3", lc_q, 0);
        runBranch("djnz4", 4'd11, 16'h0800, 16'h0000, 0, 16'h0000);
        checkOutput("lc_after4", lc_q, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
